data_mem_ctrl: RTL and testbench

- Data-memory responder. It receives the read-enable, write-enable and size strobes that the instruction decoder drives for lw/sw.
- Performs a fixed-latency word, halfword or byte access on an internal word-organised RAM.
- Reports completion and faults, and drives a stall so the datapath holds PC while an access is in flight.
- Sits between the ALU result/regfile read port and the writeback mux.

---
 rtl/data_mem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: fixed-latency byte/half/word load/store on an internal word RAM.
// Latency: request seen in IDLE at cycle 0 -> ready_out pulse at cycle ACCESS_CYCLES+1.
// Backpressure: stall_out is high while a request waits in IDLE or an access is in flight.
//
// Ports:
//   clk_in, rst_in        clock and synchronous active-high reset
//   re_in, we_in          load / store request strobes from the decoder
//   size_in               3'b001 byte, 3'b010 half, 3'b011 word; other codes fault
//   addr_in, wdata_in     byte address and store data (sub-word stores use low bits)
//   rdata_out             right-justified load data, held until the next completion
//   ready_out             one-cycle completion pulse
//   stall_out             request pending or access in flight
//   err_out               fault flag, valid with ready_out
//
// Optional feature macro: DATA_MEM_CTRL_SIGNEXT_EN
//   When defined, 3'b101 (signed byte) and 3'b110 (signed half) are legal;
//   loads sign-extend, stores behave like 3'b001 / 3'b010.

module data_mem_ctrl #(
   parameter int DEPTH         = 256,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        re_in,
   input  logic        we_in,
   input  logic [2:0]  size_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic [31:0] rdata_out,
   output logic        ready_out,
   output logic        stall_out,
   output logic        err_out
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, next_state;
   logic [3:0] cnt;
   logic capture, do_access;

   logic [AW+1:0] addr_q;
   logic [2:0]    size_q;
   logic [31:0]   wdata_q;
   logic          re_q, we_q, err_q;

   logic [31:0] mem [DEPTH];

   // One-hot access width {word, half, byte}; zero means an illegal code.
   function automatic logic [2:0] size_kind(input logic [2:0] s);
      case (s)
         3'b001:  return 3'b001;
         3'b010:  return 3'b010;
         3'b011:  return 3'b100;
`ifdef DATA_MEM_CTRL_SIGNEXT_EN
         3'b101:  return 3'b001;
         3'b110:  return 3'b010;
`endif
         default: return 3'b000;
      endcase
   endfunction

   // Fault evaluation on the live inputs, latched at capture.
   logic [2:0] in_kind;
   logic       fault_in;
   assign in_kind  = size_kind(size_in);
   assign fault_in = (re_in & we_in)
                   | ~(|in_kind)
                   | (in_kind[1] & addr_in[0])
                   | (in_kind[2] & (|addr_in[1:0]))
                   | (|addr_in[31:AW+2]);

   // ---------------- FSM ----------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (capture)
            cnt <= CNT_INIT;
         else if (state == BUSY && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   always_comb begin
      next_state = state;
      stall_out  = 1'b0;
      capture    = 1'b0;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            if (re_in | we_in) begin
               stall_out  = 1'b1;
               capture    = 1'b1;
               next_state = BUSY;
            end
         end
         BUSY: begin
            stall_out = 1'b1;
            if (cnt == 4'd0) begin
               do_access  = 1'b1;
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ---------------- access datapath ----------------
   logic [2:0]    kind_q;
   logic          sext;
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [31:0]   word_rd, rd_val, wdat;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [3:0]    be;

   assign kind_q = size_kind(size_q);
`ifdef DATA_MEM_CTRL_SIGNEXT_EN
   // Among legal codes only 3'b101/3'b110 have bit 2 set; 3'b111 faults anyway.
   assign sext = size_q[2];
`else
   assign sext = 1'b0;
`endif
   assign idx     = addr_q[AW+1:2];
   assign lane    = addr_q[1:0];
   assign word_rd = mem[idx];

   always_comb begin
      rd_byte = word_rd[7:0];
      case (lane)
         2'd1:    rd_byte = word_rd[15:8];
         2'd2:    rd_byte = word_rd[23:16];
         2'd3:    rd_byte = word_rd[31:24];
         default: rd_byte = word_rd[7:0];
      endcase
      rd_half = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

      if (kind_q[0])
         rd_val = {{24{sext & rd_byte[7]}}, rd_byte};
      else if (kind_q[1])
         rd_val = {{16{sext & rd_half[15]}}, rd_half};
      else
         rd_val = word_rd;

      // Sub-word store data is replicated so every enabled lane sees the right bits.
      if (kind_q[2]) begin
         be   = 4'b1111;
         wdat = wdata_q;
      end else if (kind_q[1]) begin
         be   = addr_q[1] ? 4'b1100 : 4'b0011;
         wdat = {2{wdata_q[15:0]}};
      end else if (kind_q[0]) begin
         be   = 4'b0001 << lane;
         wdat = {4{wdata_q[7:0]}};
      end else begin
         be   = 4'b0000;
         wdat = wdata_q;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q    <= '0;
         size_q    <= '0;
         wdata_q   <= '0;
         re_q      <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         rdata_out <= '0;
         ready_out <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         ready_out <= do_access;
         if (capture) begin
            addr_q  <= addr_in[AW+1:0];
            size_q  <= size_in;
            wdata_q <= wdata_in;
            re_q    <= re_in;
            we_q    <= we_in;
            err_q   <= fault_in;
         end
         if (do_access) begin
            rdata_out <= (re_q && !err_q) ? rd_val : 32'd0;
            err_out   <= err_q;
         end
      end
   end

   // RAM has no reset; a reset on the access edge must still suppress the write.
   always_ff @(posedge clk_in) begin
      if (do_access && !rst_in && we_q && !err_q) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: table of requests with scoreboarded completions,
// plus hand sequences for reset state, back-to-back requests and reset mid-access.
// Default DEPTH=256, ACCESS_CYCLES=2 (completion three cycles after the request).

module tb_data_mem_ctrl;

   localparam int LAT = 3;

   logic        clk_in = 1'b0;
   logic        rst_in, re_in, we_in;
   logic [2:0]  size_in;
   logic [31:0] addr_in, wdata_in;
   logic [31:0] rdata_out;
   logic        ready_out, stall_out, err_out;

   data_mem_ctrl dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .re_in     (re_in),
      .we_in     (we_in),
      .size_in   (size_in),
      .addr_in   (addr_in),
      .wdata_in  (wdata_in),
      .rdata_out (rdata_out),
      .ready_out (ready_out),
      .stall_out (stall_out),
      .err_out   (err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        re, we;
      logic [2:0]  size;
      logic [31:0] addr, wdata, exp_rd;
      logic        exp_err, chk_rd;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        err, chk_rd;
   } exp_t;

   vec_t vt[$];
   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic re, input logic we, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
      vec_t v;
      v.re = re; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
      v.exp_rd = exp_rd; v.exp_err = exp_err; v.chk_rd = chk_rd;
      vt.push_back(v);
   endtask

   // Called in a cycle where ready_out is high: pop and compare.
   task automatic on_ready(input string nm);
      exp_t e;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL %s_unexpected_ready: got ready_out=1, expected no completion", nm);
      end else begin
         n_cmp--;
         e = sbq.pop_front();
         if (e.chk_rd) chk({nm, "_rdata"}, rdata_out, e.rd);
         chk({nm, "_err"}, {31'd0, err_out}, {31'd0, e.err});
      end
   endtask

   task automatic do_req(input string nm, input vec_t v);
      exp_t e;
      bit   seen;
      int   lat;
      @(negedge clk_in);
      re_in = v.re; we_in = v.we; size_in = v.size; addr_in = v.addr; wdata_in = v.wdata;
      e.rd = v.exp_rd; e.err = v.exp_err; e.chk_rd = v.chk_rd;
      sbq.push_back(e);
      #1 chk({nm, "_stall_c0"}, {31'd0, stall_out}, 32'd1);
      seen = 0;
      lat  = -1;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk_in);
         if (c == 1) begin re_in = 1'b0; we_in = 1'b0; end
         if (ready_out) begin
            seen = 1;
            lat  = c;
            chk({nm, "_stall_done"}, {31'd0, stall_out}, 32'd0);
            on_ready(nm);
         end else begin
            chk({nm, "_stall_busy"}, {31'd0, stall_out}, 32'd1);
         end
      end
      chk({nm, "_latency"}, lat, LAT);
      if (!seen) void'(sbq.pop_back());
   endtask

   initial begin
      logic exp_se_err;
      rst_in = 1'b1; re_in = 1'b0; we_in = 1'b0;
      size_in = 3'b000; addr_in = '0; wdata_in = '0;

`ifdef DATA_MEM_CTRL_SIGNEXT_EN
      exp_se_err = 1'b0;
`else
      exp_se_err = 1'b1;
`endif
      //   re   we   size    addr          wdata         exp_rd        err  chk_rd
      add(1'b0, 1'b1, 3'b011, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
      add(1'b1, 1'b0, 3'b011, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
      add(1'b0, 1'b1, 3'b011, 32'h20,  32'h11223344, 32'h0,        1'b0, 1'b0);
      add(1'b0, 1'b1, 3'b001, 32'h22,  32'h556677AA, 32'h0,        1'b0, 1'b0);
      add(1'b1, 1'b0, 3'b011, 32'h20,  32'h0,        32'h11AA3344, 1'b0, 1'b1);
      add(1'b1, 1'b0, 3'b001, 32'h23,  32'h0,        32'h00000011, 1'b0, 1'b1);
      add(1'b1, 1'b0, 3'b010, 32'h22,  32'h0,        32'h000011AA, 1'b0, 1'b1);
      add(1'b1, 1'b0, 3'b001, 32'h21,  32'h0,        32'h00000033, 1'b0, 1'b1);
      // faults: rdata forced to 0, no RAM update
      add(1'b1, 1'b0, 3'b010, 32'h21,  32'h0,        32'h0,        1'b1, 1'b1);
      add(1'b0, 1'b1, 3'b011, 32'h22,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b1);
      add(1'b1, 1'b0, 3'b000, 32'h20,  32'h0,        32'h0,        1'b1, 1'b1);
      add(1'b1, 1'b1, 3'b011, 32'h20,  32'h0,        32'h0,        1'b1, 1'b1);
      add(1'b1, 1'b0, 3'b011, 32'h400, 32'h0,        32'h0,        1'b1, 1'b1);
      add(1'b0, 1'b1, 3'b111, 32'h20,  32'h0,        32'h0,        1'b1, 1'b1);
      add(1'b1, 1'b0, 3'b011, 32'h20,  32'h0,        32'h11AA3344, 1'b0, 1'b1);
      add(1'b0, 1'b1, 3'b011, 32'h30,  32'h12345678, 32'h0,        1'b0, 1'b0);
      // sign extension codes
      add(1'b0, 1'b1, 3'b011, 32'h40,  32'h000080F0, 32'h0,        1'b0, 1'b0);
      add(1'b1, 1'b0, 3'b101, 32'h40,  32'h0, exp_se_err ? 32'h0 : 32'hFFFFFFF0, exp_se_err, 1'b1);
      add(1'b1, 1'b0, 3'b110, 32'h40,  32'h0, exp_se_err ? 32'h0 : 32'hFFFF80F0, exp_se_err, 1'b1);
      add(1'b1, 1'b0, 3'b001, 32'h40,  32'h0,        32'h000000F0, 1'b0, 1'b1);
      add(1'b1, 1'b0, 3'b010, 32'h40,  32'h0,        32'h000080F0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 3'b010, 32'h42,  32'h1234BEEF, 32'h0,        1'b0, 1'b0);
      add(1'b1, 1'b0, 3'b011, 32'h40,  32'h0,        32'hBEEF80F0, 1'b0, 1'b1);

      // reset state
      repeat (2) @(negedge clk_in);
      chk("rst_ready", {31'd0, ready_out}, 32'd0);
      chk("rst_err",   {31'd0, err_out},   32'd0);
      chk("rst_rdata", rdata_out,          32'd0);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      rst_in = 1'b0;

      foreach (vt[i]) do_req($sformatf("vec%0d", i), vt[i]);

      // back-to-back: re held 12 cycles -> completions at cycles 3, 7, 11
      @(negedge clk_in);
      re_in = 1'b1; we_in = 1'b0; size_in = 3'b011; addr_in = 32'h10;
      repeat (3) sbq.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk_in);
         #1;
         chk($sformatf("b2b_ready_c%0d", c), {31'd0, ready_out}, {31'd0, (c % 4) == 3});
         chk($sformatf("b2b_stall_c%0d", c), {31'd0, stall_out}, {31'd0, (c % 4) != 3});
         if (ready_out) on_ready($sformatf("b2b_c%0d", c));
      end
      @(negedge clk_in);
      re_in = 1'b0;
      chk("b2b_drain", sbq.size(), 32'd0);
      sbq.delete();
      repeat (4) @(negedge clk_in);

      // reset in first BUSY cycle aborts a store
      re_in = 1'b0; we_in = 1'b1; size_in = 3'b011; addr_in = 32'h30; wdata_in = 32'hCAFEF00D;
      @(negedge clk_in);
      we_in = 1'b0; rst_in = 1'b1;
      chk("rmid_stall_busy", {31'd0, stall_out}, 32'd1);
      @(negedge clk_in);
      rst_in = 1'b0;
      chk("rmid_ready", {31'd0, ready_out}, 32'd0);
      chk("rmid_stall", {31'd0, stall_out}, 32'd0);
      chk("rmid_rdata", rdata_out,          32'd0);
      chk("rmid_err",   {31'd0, err_out},   32'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_in);
         chk($sformatf("rmid_noready_c%0d", c), {31'd0, ready_out}, 32'd0);
      end
      begin
         vec_t v;
         v.re = 1'b1; v.we = 1'b0; v.size = 3'b011; v.addr = 32'h30; v.wdata = 32'h0;
         v.exp_rd = 32'h12345678; v.exp_err = 1'b0; v.chk_rd = 1'b1;
         do_req("rmid_reload", v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
